// File: rtl/st_stub_pair_sequencer.sv
// st_stub_pair_sequencer
// Pops one per-crossing stub-count word, walks every inner stub against the
// outer stubs three at a time, drives the stub memory read addresses and
// repackages the returned stubs as a valid/ready stream of candidate pairs.
// Read issue is credit-limited so the 4-entry output buffer can never overflow,
// even with MEM_LAT reads still in flight when downstream stalls.

module st_stub_pair_sequencer #(
    parameter int ADR_BITS  = 6,
    parameter int CNT_BITS  = 6,
    parameter int STUB_BITS = 36,
    parameter int MEM_LAT   = 2
) (
    input  logic                  proc_clk,
    input  logic                  reset,
    input  logic                  stub_cnt_fifo_empty,
    output logic                  stub_cnt_fifo_rd_en,
    input  logic [2*CNT_BITS-1:0] struct_stub_cnt,
    output logic [ADR_BITS-1:0]   in_stub_adr,
    output logic [ADR_BITS-1:0]   out_stub_adr,
    input  logic [STUB_BITS-1:0]  struct_in_stub,
    input  logic [STUB_BITS-1:0]  struct_out_stub_a,
    input  logic [STUB_BITS-1:0]  struct_out_stub_b,
    input  logic [STUB_BITS-1:0]  struct_out_stub_c,
    output logic                  pr_valid,
    input  logic                  pr_ready,
    output logic [STUB_BITS-1:0]  pr_in_stub,
    output logic [STUB_BITS-1:0]  pr_out_stub_a,
    output logic [STUB_BITS-1:0]  pr_out_stub_b,
    output logic [STUB_BITS-1:0]  pr_out_stub_c,
    output logic [2:0]            pr_mask,
    output logic                  pr_last,
    output logic                  busy,
    output logic                  xing_done
);

    localparam int NUM_LANES = 3;
    localparam int BUF_DEPTH = 4;
    localparam int BUF_AW    = 2;
    localparam int CRD_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_ISSUE,
        S_DRAIN
    } state_t;

    // Tag that travels alongside a memory read.
    typedef struct packed {
        logic [NUM_LANES-1:0] mask;
        logic                 last;
    } tag_t;

    // One buffered pair group; lane 0 is lane a.
    typedef struct packed {
        logic [STUB_BITS-1:0]                in_stub;
        logic [NUM_LANES-1:0][STUB_BITS-1:0] out_stub;
        logic [NUM_LANES-1:0]                mask;
        logic                                last;
    } grp_t;

    state_t state, state_nxt;

    logic [CNT_BITS-1:0] nin, nout;
    logic [CNT_BITS-1:0] idx_i, idx_j;
    logic [CRD_W-1:0]    credits;

    // Stage s holds the tag of the read issued s cycles ago.
    logic [MEM_LAT:1]    vld_pipe;
    tag_t [MEM_LAT:1]    tag_pipe;

    grp_t                buf_mem [BUF_DEPTH];
    logic [BUF_AW-1:0]   wr_ptr, rd_ptr;
    logic [BUF_AW:0]     buf_cnt;
    grp_t                head;

    logic                issue, issue_last, xfer, buf_wr;
    logic                rd_en_c, xdone_c;
    logic [CNT_BITS:0]   j_ext, nout_ext, j_step;
    logic [NUM_LANES-1:0] lane_mask;

    // Index arithmetic is one bit wider so j+k never wraps at the max count.
    assign j_ext    = {1'b0, idx_j};
    assign nout_ext = {1'b0, nout};
    assign j_step   = j_ext + (CNT_BITS+1)'(NUM_LANES);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_mask[k] = (j_ext + (CNT_BITS+1)'(k)) < nout_ext;
    end

    assign issue      = (state == S_ISSUE) && (credits != '0);
    assign issue_last = (idx_i == nin - CNT_BITS'(1)) && (j_step >= nout_ext);
    assign pr_valid   = (buf_cnt != '0);
    assign xfer       = pr_valid && pr_ready;
    assign buf_wr     = vld_pipe[MEM_LAT];

    assign in_stub_adr  = ADR_BITS'(idx_i);
    assign out_stub_adr = ADR_BITS'(idx_j);

    assign busy                = (state != S_IDLE);
    assign stub_cnt_fifo_rd_en = rd_en_c && !reset;
    assign xing_done           = xdone_c && !reset;

    // State register.
    always_ff @(posedge proc_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic plus the pop strobe and crossing-done pulse.
    always_comb begin
        state_nxt = state;
        rd_en_c   = 1'b0;
        xdone_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!stub_cnt_fifo_empty) begin
                    rd_en_c   = 1'b1;
                    state_nxt = S_POP;
                end
            end
            S_POP:  state_nxt = S_LOAD;
            S_LOAD: begin
                if (struct_stub_cnt[CNT_BITS-1:0] == '0 ||
                    struct_stub_cnt[2*CNT_BITS-1:CNT_BITS] == '0)
                    state_nxt = S_DRAIN;
                else
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue && issue_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Hold here so the memory page stays valid until all reads retire.
                if (vld_pipe == '0 && buf_cnt == '0) begin
                    xdone_c   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Crossing counts and the inner/outer walk indices.
    always_ff @(posedge proc_clk) begin
        if (reset) begin
            nin   <= '0;
            nout  <= '0;
            idx_i <= '0;
            idx_j <= '0;
        end else if (state == S_LOAD) begin
            nin   <= struct_stub_cnt[CNT_BITS-1:0];
            nout  <= struct_stub_cnt[2*CNT_BITS-1:CNT_BITS];
            idx_i <= '0;
            idx_j <= '0;
        end else if (issue) begin
            if (j_step < nout_ext) begin
                idx_j <= j_step[CNT_BITS-1:0];
            end else begin
                idx_j <= '0;
                idx_i <= idx_i + CNT_BITS'(1);
            end
        end
    end

    // Credits track free buffer slots not yet claimed by an in-flight read.
    always_ff @(posedge proc_clk) begin
        if (reset) credits <= CRD_W'(BUF_DEPTH);
        else       credits <= credits - {{(CRD_W-1){1'b0}}, issue} + {{(CRD_W-1){1'b0}}, xfer};
    end

    // Tag pipeline matched to the memory read latency.
    always_ff @(posedge proc_clk) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            tag_pipe[1] <= '{mask: lane_mask, last: issue_last};
            for (int s = 2; s <= MEM_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    // Output buffer storage; returned stubs are written with their tag.
    always_ff @(posedge proc_clk) begin
        if (buf_wr) begin
            buf_mem[wr_ptr] <= '{in_stub:  struct_in_stub,
                                 out_stub: {struct_out_stub_c, struct_out_stub_b, struct_out_stub_a},
                                 mask:     tag_pipe[MEM_LAT].mask,
                                 last:     tag_pipe[MEM_LAT].last};
        end
    end

    // Output buffer pointers and occupancy.
    always_ff @(posedge proc_clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (buf_wr) wr_ptr <= wr_ptr + BUF_AW'(1);
            if (xfer)   rd_ptr <= rd_ptr + BUF_AW'(1);
            buf_cnt <= buf_cnt + {{BUF_AW{1'b0}}, buf_wr} - {{BUF_AW{1'b0}}, xfer};
        end
    end

    // First-word-fall-through head; outputs read zero whenever nothing is presented.
    always_comb begin
        head          = buf_mem[rd_ptr];
        pr_in_stub    = '0;
        pr_out_stub_a = '0;
        pr_out_stub_b = '0;
        pr_out_stub_c = '0;
        pr_mask       = '0;
        pr_last       = 1'b0;
        if (pr_valid) begin
            pr_in_stub    = head.in_stub;
            pr_out_stub_a = head.out_stub[0];
            pr_out_stub_b = head.out_stub[1];
            pr_out_stub_c = head.out_stub[2];
            pr_mask       = head.mask;
            pr_last       = head.last;
        end
    end

endmodule
